shared_nibble_adder_ctrl: RTL and testbench
===========================================

# shared_nibble_adder_ctrl

Sequencing controller that time-shares one 4-bit add slice (with carry) between two requesters. Each accepted request is a multi-nibble addition, `a + b + cin`, processed one nibble per cycle LSB-first, with the carry held in a register between nibbles. The block sits between operand producers and a single result consumer and uses valid/ready handshakes on all sides. It replaces duplicated wide registered adders in mode-exercising benchmarks with one shared, scheduled slice.

## Interface
- `NIBBLES`, default 4: operand width in nibbles; `W = 4*NIBBLES`; legal range 1..16.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `req0_valid`  in  1: requester 0 has an operation pending.
- `req0_ready`  out  1: requester 0 operation accepted this cycle.
- `req0_a`, `req0_b`  in  W: operands.
- `req0_cin`  in  1: carry-in.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_cin`: same as requester 0, for requester 1.
- `rsp_valid`  out  1: result available.
- `rsp_ready`  in  1: consumer accepts the result.
- `rsp_id`  out  1: index of the requester that owns the result.
- `rsp_sum`  out  W: low W bits of `a + b + cin`.
- `rsp_cout`  out  1: bit W of the sum.

## Operation
- FSM states: IDLE, ADD, DONE.
- **IDLE**
  - If any `reqX_valid` is high, grant one requester and assert its `reqX_ready` combinationally in the same cycle. Only one ready is ever high.
  - On the handshake: latch a, b and cin into operand registers, set `rsp_id` to the granted index, clear the nibble counter, update `last_grant`, and go to ADD.
  - Arbitration is round-robin. With both valid, grant the requester that is not `last_grant`. With one valid, grant it regardless of `last_grant`.
- **ADD**
  - Each cycle, compute nibble k of `a + b + carry` in the slice and write it into `rsp_sum[4k+3:4k]`. The carry register takes the slice carry-out.
  - k counts 0..NIBBLES-1. After k = NIBBLES-1, load `rsp_cout` from the final carry and go to DONE.
  - The first nibble uses the latched cin as its carry.
- **DONE**
  - `rsp_valid` is high. `rsp_sum`, `rsp_cout` and `rsp_id` stay stable until `rsp_valid && rsp_ready`, then go to IDLE.
  - No requester ready is asserted in ADD or DONE.
- Arithmetic is unsigned modulo 2^W. The carry out of the top nibble appears only on `rsp_cout`.
- Requesters must hold valid and operands stable until ready. The block does not check this.

## Timing
- Reset values:
  - state = IDLE, `last_grant` = 1, so requester 0 wins the first tie.
  - `req0_ready` = `req1_ready` = 0, `rsp_valid` = 0, `rsp_id` = 0, `rsp_sum` = 0, `rsp_cout` = 0.
  - Carry register = 0, counter = 0.
- Latency: a request handshake at edge t gives ADD in cycles t+1..t+NIBBLES and `rsp_valid` = 1 from cycle t+NIBBLES+1.
- Throughput:
  - The response handshake returns the FSM to IDLE on the next cycle.
  - The earliest next accept is that IDLE cycle, so back-to-back operations take NIBBLES+2 cycles each with `rsp_ready` tied high.
  - Backpressure extends DONE without limit and without losing data.
- Simultaneous valid on both requesters is resolved by round-robin only. A requester waiting in IDLE behind the other is served next.
- Reset mid-operation (ADD or DONE): the operation is dropped, no response is produced, and all outputs take their reset values asynchronously.
- `rsp_valid` and the data outputs are registered. `reqX_ready` is combinational from state, `last_grant` and both valids.

## Structure
- Package `shared_nibble_adder_pkg`:
  - state enum `{IDLE, ADD, DONE}`
  - `NIBBLE_W = 4`
  - requester-count constant `N_REQ = 2`
- Sub-module `nibble_add_slice`: purely combinational `{cout, s[3:0]} = a[3:0] + b[3:0] + cin`. It is instanced once and owns all adder logic.
- The top level holds the FSM, arbiter, operand and result registers, the carry register and the counter.

## Test plan
- **Single op, carry-in.** NIBBLES=4, req0: a=0x1234, b=0x0FFF, cin=1. Expect `rsp_sum`=0x2234, `rsp_cout`=0, `rsp_id`=0, and `rsp_valid` exactly 5 cycles after the handshake edge.
- **Full carry ripple.** req1: a=0xFFFF, b=0x0001, cin=0. Expect `rsp_sum`=0x0000, `rsp_cout`=1, `rsp_id`=1.
- **Tie after reset.** Both valid, with req0 a=1,b=1 and req1 a=2,b=2, both cin=0. Expect responses in order id 0 (sum 0x0002), then id 1 (sum 0x0004), and each ready pulsed exactly one cycle.
- **Backpressure.** Hold `rsp_ready`=0 for 6 cycles in DONE. Expect `rsp_valid`, `rsp_sum` and `rsp_id` stable, and both readies at 0 throughout. Release, then expect IDLE on the next cycle.
- **Reset mid-operation.** Assert `rst` during the second ADD cycle. Expect all outputs at reset values immediately. After release, a new req0 (0x0001 + 0x0001) returns 0x0002 with no stale response.
- **Fairness.** Keep both valid continuously for 6 operations. Expect `rsp_id` to alternate 0,1,0,1,0,1.

Source files
------------

// File: rtl/shared_nibble_adder_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder controller.
//   NIBBLE_W : width of the shared add slice
//   N_REQ    : number of requesters sharing the slice
//   state_e  : controller FSM states
package shared_nibble_adder_pkg;

  localparam int NIBBLE_W = 4;
  localparam int N_REQ    = 2;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_e;

endpackage

// File: rtl/shared_nibble_adder_ctrl_if.sv
// Handshake bundle between the two operand producers, the result consumer
// and the shared adder controller.
//   req0_* / req1_* : valid/ready request channels carrying a, b, cin
//   rsp_*           : valid/ready response channel carrying id, sum, cout
// master = producers/consumer side, slave = controller side.
interface shared_nibble_adder_ctrl_if
  import shared_nibble_adder_pkg::*;
#(
  parameter int NIBBLES = 4
) ();

  localparam int W = NIBBLE_W * NIBBLES;

  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic         req0_cin;

  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic         req1_cin;

  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [W-1:0] rsp_sum;
  logic         rsp_cout;

  modport master (
    output req0_valid, req0_a, req0_b, req0_cin,
    output req1_valid, req1_a, req1_b, req1_cin,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_sum, rsp_cout
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_cin,
    input  req1_valid, req1_a, req1_b, req1_cin,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_sum, rsp_cout
  );

endinterface

// File: rtl/shared_nibble_adder_ctrl_nibble_add_slice.sv
// Purely combinational 4-bit add slice with carry, shared by all requesters.
//   a_i, b_i : nibble operands
//   cin_i    : carry in
//   s_o      : nibble sum
//   cout_o   : carry out
module nibble_add_slice
  import shared_nibble_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a_i,
  input  logic [NIBBLE_W-1:0] b_i,
  input  logic                cin_i,
  output logic [NIBBLE_W-1:0] s_o,
  output logic                cout_o
);

  assign {cout_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{NIBBLE_W{1'b0}}, cin_i};

endmodule

// File: rtl/shared_nibble_adder_ctrl.sv
// Time-shares one nibble add slice between two requesters. Each accepted
// request computes a + b + cin one nibble per cycle, LSB first, then holds
// the result until the consumer takes it.
//   clk  : clock, all state on the rising edge
//   rst  : asynchronous active-high reset
//   bus  : slave side of the request/response handshake bundle
// NIBBLES must match the parameter of the connected interface instance.
module shared_nibble_adder_ctrl
  import shared_nibble_adder_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  shared_nibble_adder_ctrl_if.slave   bus
);

  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int IW = $clog2(N_REQ);
  localparam logic [CW-1:0] LAST_NIB = CW'(NIBBLES - 1);

  state_e          state_q;
  logic [IW-1:0]   last_grant_q;
  logic [IW-1:0]   id_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    sum_q;
  logic [W-1:0]    sum_d;
  logic            carry_q;
  logic            cout_q;
  logic            valid_q;
  logic [CW-1:0]   cnt_q;

  logic            grant0;
  logic            grant1;

  logic [NIBBLE_W-1:0] a_nib [NIBBLES];
  logic [NIBBLE_W-1:0] b_nib [NIBBLES];
  logic [NIBBLE_W-1:0] slice_s;
  logic                slice_cout;

  // Round-robin grant: a lone requester always wins; on a tie the one that
  // was not served last wins. Readies are held low while reset is active so
  // every output shows its reset value.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst && state_q == IDLE) begin
      if (bus.req0_valid && (!bus.req1_valid || last_grant_q == IW'(1))) begin
        grant0 = 1'b1;
      end else if (bus.req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;

  // Split the latched operands into nibbles and steer the slice result into
  // the nibble position selected by the counter.
  generate
    for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
      assign a_nib[gi] = a_q[gi*NIBBLE_W +: NIBBLE_W];
      assign b_nib[gi] = b_q[gi*NIBBLE_W +: NIBBLE_W];
      assign sum_d[gi*NIBBLE_W +: NIBBLE_W] =
        (cnt_q == CW'(gi)) ? slice_s : sum_q[gi*NIBBLE_W +: NIBBLE_W];
    end
  endgenerate

  nibble_add_slice u_slice (
    .a_i    (a_nib[cnt_q]),
    .b_i    (b_nib[cnt_q]),
    .cin_i  (carry_q),
    .s_o    (slice_s),
    .cout_o (slice_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= IW'(1);
      id_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      sum_q        <= '0;
      carry_q      <= 1'b0;
      cout_q       <= 1'b0;
      valid_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant0 || grant1) begin
            a_q          <= grant1 ? bus.req1_a : bus.req0_a;
            b_q          <= grant1 ? bus.req1_b : bus.req0_b;
            carry_q      <= grant1 ? bus.req1_cin : bus.req0_cin;
            id_q         <= IW'(grant1);
            last_grant_q <= IW'(grant1);
            cnt_q        <= '0;
            state_q      <= ADD;
          end
        end
        ADD: begin
          sum_q   <= sum_d;
          carry_q <= slice_cout;
          if (cnt_q == LAST_NIB) begin
            cout_q  <= slice_cout;
            valid_q <= 1'b1;
            cnt_q   <= '0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rsp_valid = valid_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_sum   = sum_q;
  assign bus.rsp_cout  = cout_q;

endmodule

// File: tb/tb_shared_nibble_adder_ctrl.sv
// Self-checking bench for shared_nibble_adder_ctrl (NIBBLES = 4).
module tb_shared_nibble_adder_ctrl;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shared_nibble_adder_ctrl_if #(.NIBBLES(NIB)) bus ();

  shared_nibble_adder_ctrl #(.NIBBLES(NIB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int           id;
    logic [W-1:0] sum;
    logic         cout;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  int           errors = 0;
  int           checks = 0;
  int           rdy_cycles[2];
  logic [W-1:0] op_a[2][8];
  logic [W-1:0] op_b[2][8];
  logic         op_c[2][8];

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic void push_exp(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin);
    logic [W:0] t;
    exp_t       e;
    t      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    e.id   = id;
    e.sum  = t[W-1:0];
    e.cout = t[W];
    sb.push_back(e);
  endfunction

  function automatic logic rdy(input int id);
    return (id == 0) ? bus.req0_ready : bus.req1_ready;
  endfunction

  task automatic set_req(input int id, input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c);
    if (id == 0) begin
      bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_cin = c;
    end else begin
      bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_cin = c;
    end
  endtask

  // Present one request and wait (bounded) for its handshake edge; returns
  // 1 time unit after that edge. drop=1 lowers valid afterwards.
  task automatic send(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                      input bit drop);
    int n = 0;
    set_req(id, 1'b1, a, b, c);
    @(negedge clk);
    while (!rdy(id) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!rdy(id)) begin
      check_value("req_accept_timeout", 32'(id), 32'hFF);
      set_req(id, 1'b0, a, b, c);
    end else begin
      @(posedge clk);
      #1;
      if (drop) set_req(id, 1'b0, a, b, c);
    end
  endtask

  task automatic run_seq(input int id, input int n);
    for (int k = 0; k < n; k++) begin
      send(id, op_a[id][k], op_b[id][k], op_c[id][k], k == n - 1);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || bus.rsp_valid) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_value("drain_pending", 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    sb.delete();
    rst = 1'b0;
  endtask

  // Response monitor: compares every response handshake with the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.req0_ready) rdy_cycles[0]++;
      if (bus.req1_ready) rdy_cycles[1]++;
      if (bus.req0_ready && bus.req1_ready) check_value("single_ready", 32'd2, 32'd1);
      if (bus.rsp_valid && bus.rsp_ready) begin
        $display("rsp id=%0d sum=0x%04h cout=%0d", bus.rsp_id, bus.rsp_sum, bus.rsp_cout);
        if (sb.size() == 0) begin
          check_value("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check_value("rsp_id", 32'(bus.rsp_id), 32'(mon_e.id));
          check_value("rsp_sum", 32'(bus.rsp_sum), 32'(mon_e.sum));
          check_value("rsp_cout", 32'(bus.rsp_cout), 32'(mon_e.cout));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int           n;
    logic [W-1:0] hold_sum;

    rst = 1'b1;
    set_req(0, 1'b0, '0, '0, 1'b0);
    set_req(1, 1'b0, '0, '0, 1'b0);
    bus.rsp_ready = 1'b1;
    rdy_cycles = '{0, 0};

    // Reset values, with both requesters asking so ready gating is visible.
    @(posedge clk);
    #1;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    check_value("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_value("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    check_value("rst_rsp_sum", 32'(bus.rsp_sum), 32'd0);
    check_value("rst_rsp_cout", 32'(bus.rsp_cout), 32'd0);
    check_value("rst_req0_ready", 32'(bus.req0_ready), 32'd0);
    check_value("rst_req1_ready", 32'(bus.req1_ready), 32'd0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single op with carry-in, plus latency from the handshake edge.
    push_exp(0, 16'h1234, 16'h0FFF, 1'b1);
    send(0, 16'h1234, 16'h0FFF, 1'b1, 1'b1);
    n = 0;
    while (!bus.rsp_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_value("edges_to_rsp_valid", 32'(n), 32'(NIB));
    drain();

    // Full carry ripple on requester 1.
    push_exp(1, 16'hFFFF, 16'h0001, 1'b0);
    send(1, 16'hFFFF, 16'h0001, 1'b0, 1'b1);
    drain();

    // Tie right after reset: requester 0 first, each ready one cycle.
    do_reset();
    rdy_cycles = '{0, 0};
    op_a[0][0] = 16'd1; op_b[0][0] = 16'd1; op_c[0][0] = 1'b0;
    op_a[1][0] = 16'd2; op_b[1][0] = 16'd2; op_c[1][0] = 1'b0;
    push_exp(0, 16'd1, 16'd1, 1'b0);
    push_exp(1, 16'd2, 16'd2, 1'b0);
    fork
      run_seq(0, 1);
      run_seq(1, 1);
    join
    drain();
    check_value("tie_req0_ready_cycles", 32'(rdy_cycles[0]), 32'd1);
    check_value("tie_req1_ready_cycles", 32'(rdy_cycles[1]), 32'd1);

    // Backpressure: hold DONE for 6 cycles with requester 1 waiting.
    bus.rsp_ready = 1'b0;
    push_exp(0, 16'h00AB, 16'h0011, 1'b0);
    push_exp(1, 16'h0003, 16'h0004, 1'b0);
    send(0, 16'h00AB, 16'h0011, 1'b0, 1'b1);
    set_req(1, 1'b1, 16'h0003, 16'h0004, 1'b0);
    n = 0;
    while (!bus.rsp_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_value("bp_rsp_valid_seen", 32'(bus.rsp_valid), 32'd1);
    hold_sum = bus.rsp_sum;
    check_value("bp_sum_value", 32'(hold_sum), 32'h00BC);
    repeat (6) begin
      @(posedge clk);
      #1;
      check_value("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check_value("bp_rsp_sum", 32'(bus.rsp_sum), 32'(hold_sum));
      check_value("bp_rsp_id", 32'(bus.rsp_id), 32'd0);
      check_value("bp_req0_ready", 32'(bus.req0_ready), 32'd0);
      check_value("bp_req1_ready", 32'(bus.req1_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_value("bp_idle_next_req1_ready", 32'(bus.req1_ready), 32'd1);
    @(posedge clk);
    #1;
    set_req(1, 1'b0, 16'h0003, 16'h0004, 1'b0);
    drain();

    // Reset during the second ADD cycle; the dropped op must never respond.
    send(1, 16'h1234, 16'h1111, 1'b0, 1'b1);
    @(posedge clk);
    #3;
    set_req(0, 1'b1, 16'h0001, 16'h0001, 1'b0);
    rst = 1'b1;
    #1;
    check_value("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_value("midrst_rsp_id", 32'(bus.rsp_id), 32'd0);
    check_value("midrst_rsp_sum", 32'(bus.rsp_sum), 32'd0);
    check_value("midrst_rsp_cout", 32'(bus.rsp_cout), 32'd0);
    check_value("midrst_req0_ready", 32'(bus.req0_ready), 32'd0);
    check_value("midrst_req1_ready", 32'(bus.req1_ready), 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    push_exp(0, 16'h0001, 16'h0001, 1'b0);
    send(0, 16'h0001, 16'h0001, 1'b0, 1'b1);
    drain();

    // Fairness: both valid continuously for 6 ops, ids must alternate 0,1,...
    do_reset();
    for (int k = 0; k < 3; k++) begin
      for (int r = 0; r < 2; r++) begin
        op_a[r][k] = W'($urandom());
        op_b[r][k] = W'($urandom());
        op_c[r][k] = 1'($urandom_range(1, 0));
      end
    end
    for (int k = 0; k < 3; k++) begin
      push_exp(0, op_a[0][k], op_b[0][k], op_c[0][k]);
      push_exp(1, op_a[1][k], op_b[1][k], op_c[1][k]);
    end
    fork
      run_seq(0, 3);
      run_seq(1, 3);
    join
    drain();

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
